// File: rtl/serial_bridge_pkg.sv
// Shared types and constants for the serial word bridge: FSM state encoding
// and the address code that marks the one-cycle stall before byte transfer.
package serial_bridge_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      STALL = 2'd1,
      XFER  = 2'd2,
      DONE  = 2'd3
   } state_t;

   // All ones at the given address width; saturates at 64 bits.
   function automatic logic [63:0] stall_code(input int unsigned addr_w);
      if (addr_w >= 64) return '1;
      return (64'd1 << addr_w) - 64'd1;
   endfunction

endpackage

// File: rtl/serial_bridge_lane_ctr.sv
// Byte index counter for one word transfer plus the word lane that index maps
// to, honouring the byte ordering chosen by LSB_FIRST.
module serial_bridge_lane_ctr #(
   parameter  int WORD_BYTES = 4,
   parameter  bit LSB_FIRST  = 1'b1,
   localparam int IDX_W      = $clog2(WORD_BYTES + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             advance,
   output logic [IDX_W-1:0] idx,
   output logic [IDX_W-1:0] lane,
   output logic             last
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_BYTES - 1);

   assign last = (idx == LAST_IDX);
   assign lane = LSB_FIRST ? idx : (LAST_IDX - idx);

   // Counts only while transferring and falls back to zero otherwise, so the
   // next transfer always starts at byte 0 without an explicit clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idx <= '0;
      end else if (advance && !last) begin
         idx <= idx + IDX_W'(1);
      end else begin
         idx <= '0;
      end
   end

endmodule

// File: rtl/serial_word_bridge.sv
// Word-to-byte-serial bridge: accepts a load/store word request, stalls one
// cycle, moves WORD_BYTES bytes over data_in/data_out, then pulses rsp_valid.
module serial_word_bridge
   import serial_bridge_pkg::*;
#(
   parameter int BYTE_W     = 8,
   parameter int WORD_BYTES = 4,
   parameter int ADDR_W     = 8,
   parameter bit LSB_FIRST  = 1'b1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         req_valid,
   output logic                         req_ready,
   input  logic                         req_write,
   input  logic [BYTE_W*WORD_BYTES-1:0] req_wdata,
   output logic                         rsp_valid,
   output logic [BYTE_W*WORD_BYTES-1:0] rsp_rdata,
   input  logic [BYTE_W-1:0]            data_in,
   output logic [BYTE_W-1:0]            data_out,
   output logic [ADDR_W-1:0]            address_out,
   output logic                         mem_read,
   output logic                         mem_write
);

   localparam int WORD_W = BYTE_W * WORD_BYTES;
   localparam int IDX_W  = $clog2(WORD_BYTES + 1);
   localparam logic [ADDR_W-1:0] STALL_ADDR = ADDR_W'(stall_code(ADDR_W));

   // Sequence numbers 1..N must never collide with the stall code.
   if (WORD_BYTES < 1 || 64'(WORD_BYTES) >= stall_code(ADDR_W)) begin : g_param_err
      $error("serial_word_bridge: WORD_BYTES must be >= 1 and < 2**ADDR_W-1");
   end

   state_t             state;
   state_t             state_nx;
   logic               wr_q;
   logic [WORD_W-1:0]  wdata_q;
   logic [WORD_W-1:0]  word_buf;
   logic [WORD_W-1:0]  word_nx;
   logic [IDX_W-1:0]   idx;
   logic [IDX_W-1:0]   lane;
   logic               last;
   logic               accept;
   logic               in_xfer;

   assign accept  = req_valid && (state == IDLE);
   assign in_xfer = (state == XFER);

   serial_bridge_lane_ctr #(
      .WORD_BYTES (WORD_BYTES),
      .LSB_FIRST  (LSB_FIRST)
   ) u_lane_ctr (
      .clk     (clk),
      .rst     (rst),
      .advance (in_xfer),
      .idx     (idx),
      .lane    (lane),
      .last    (last)
   );

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (req_valid) state_nx = STALL;
         STALL:   state_nx = XFER;
         XFER:    if (last) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      req_ready   = 1'b0;
      rsp_valid   = 1'b0;
      address_out = '0;
      data_out    = '0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      case (state)
         IDLE: req_ready = 1'b1;
         STALL: begin
            address_out = STALL_ADDR;
            mem_read    = !wr_q;
            mem_write   = wr_q;
         end
         XFER: begin
            address_out = ADDR_W'(idx) + ADDR_W'(1);
            mem_read    = !wr_q;
            mem_write   = wr_q;
            if (wr_q) data_out = wdata_q[int'(lane)*BYTE_W +: BYTE_W];
         end
         DONE:    rsp_valid = 1'b1;
         default: ;
      endcase
   end

   // Assembly buffer with the current serial byte merged into its lane; the
   // final merge goes straight to rsp_rdata so it is visible in DONE.
   always_comb begin
      word_nx = word_buf;
      word_nx[int'(lane)*BYTE_W +: BYTE_W] = data_in;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         wr_q      <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         state <= state_nx;
         if (accept) wr_q <= req_write;
         if (in_xfer && !wr_q && last) rsp_rdata <= word_nx;
      end
   end

   // Every lane is rewritten before a load completes, so the data registers
   // need no reset; a partial word is simply never published.
   always_ff @(posedge clk) begin
      if (accept) wdata_q <= req_wdata;
      if (in_xfer && !wr_q) word_buf <= word_nx;
   end

endmodule
